// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
// Shares one register-file read-port pair between NUM_REQ requesters.
// A round-robin grant picks one requester per cycle, its indices are
// registered onto addra/addrb, and a delay pipe matching the register-file
// latency returns the operand pair with a one-hot valid and the request tag.
module rf_read_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int RF_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addra,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addrb,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic                        block_i,
  input  logic                        flush_i,
  output logic [ADDR_W-1:0]           addra,
  output logic [ADDR_W-1:0]           addrb,
  input  logic [DATA_W-1:0]           dataa,
  input  logic [DATA_W-1:0]           datab,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [DATA_W-1:0]           rsp_dataa,
  output logic [DATA_W-1:0]           rsp_datab
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Stage k of the pipe is visible k+1 cycles after the grant, so the
  // last stage lines up with data arriving RF_LATENCY cycles after addra.
  localparam int DEPTH = RF_LATENCY + 1;

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   winner_s;
  logic [PTR_W-1:0]   ptr_next_s;
  logic [PTR_W-1:0]   cand_s;
  logic [PTR_W:0]     sum_s;
  logic               found_s;
  logic               grant_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic [ADDR_W-1:0]  addra_r;
  logic [ADDR_W-1:0]  addrb_r;

  logic               pipe_vld_r [DEPTH];
  logic [NUM_REQ-1:0] pipe_id_r  [DEPTH];
  logic [TAG_W-1:0]   pipe_tag_r [DEPTH];

  // Priority scan starting at the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {PTR_W{1'b0}};
    sum_s    = {(PTR_W+1){1'b0}};
    cand_s   = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PTR_W-1:0];
      if (!found_s && req_valid[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // A grant is suppressed while in reset, blocked or flushing.
  assign grant_s = reset & found_s & ~block_i & ~flush_i;

  // One-hot ready for the winner only.
  always_comb begin
    grant_oh_s = {NUM_REQ{1'b0}};
    if (grant_s) begin
      grant_oh_s[winner_s] = 1'b1;
    end else begin
      grant_oh_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready = grant_oh_s;

  // Pointer moves just past the winner, wrapping from NUM_REQ-1 to 0.
  always_comb begin
    ptr_next_s = {PTR_W{1'b0}};
    if (winner_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = winner_s + PTR_W'(1);
    end
  end

  // Pointer and register-file addresses advance only on a handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r <= {PTR_W{1'b0}};
      addra_r  <= {ADDR_W{1'b0}};
      addrb_r  <= {ADDR_W{1'b0}};
    end else if (grant_s) begin
      rr_ptr_r <= ptr_next_s;
      addra_r  <= req_addra[winner_s*ADDR_W +: ADDR_W];
      addrb_r  <= req_addrb[winner_s*ADDR_W +: ADDR_W];
    end
  end

  assign addra = addra_r;
  assign addrb = addrb_r;

  // Delay pipe tracking in-flight reads; flush and reset kill every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        pipe_vld_r[s] <= 1'b0;
        pipe_id_r[s]  <= {NUM_REQ{1'b0}};
        pipe_tag_r[s] <= {TAG_W{1'b0}};
      end
    end else if (flush_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        pipe_vld_r[s] <= 1'b0;
      end
    end else begin
      pipe_vld_r[0] <= grant_s;
      pipe_id_r[0]  <= grant_oh_s;
      pipe_tag_r[0] <= req_tag[winner_s*TAG_W +: TAG_W];
      for (int s = 1; s < DEPTH; s++) begin
        pipe_vld_r[s] <= pipe_vld_r[s-1];
        pipe_id_r[s]  <= pipe_id_r[s-1];
        pipe_tag_r[s] <= pipe_tag_r[s-1];
      end
    end
  end

  // Response is driven from the last pipe stage; tag reads zero when idle.
  always_comb begin
    rsp_valid = {NUM_REQ{1'b0}};
    rsp_tag   = {TAG_W{1'b0}};
    if (pipe_vld_r[RF_LATENCY]) begin
      rsp_valid = pipe_id_r[RF_LATENCY];
      rsp_tag   = pipe_tag_r[RF_LATENCY];
    end else begin
      rsp_valid = {NUM_REQ{1'b0}};
      rsp_tag   = {TAG_W{1'b0}};
    end
  end

  assign rsp_dataa = dataa;
  assign rsp_datab = datab;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb_rf_read_arbiter
// Directed and random stimulus for rf_read_arbiter against a cycle-indexed
// response schedule; a second instance covers NUM_REQ=4, RF_LATENCY=3.
module tb_rf_read_arbiter;

  localparam int N   = 3;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addra, req_addrb;
  logic [N*TW-1:0] req_tag;
  logic            block_i, flush_i;
  logic [AW-1:0]   addra, addrb;
  logic [DW-1:0]   dataa, datab, rsp_dataa, rsp_datab;
  logic [TW-1:0]   rsp_tag;

  logic [3:0]      v4, rdy4, rv4;
  logic [4*AW-1:0] a4, b4;
  logic [4*TW-1:0] t4;
  logic [AW-1:0]   addra4, addrb4;
  logic [TW-1:0]   rt4;
  logic [DW-1:0]   rda4, rdb4;
  logic [DW-1:0]   zero_data = 32'h0;
  logic            zero_bit  = 1'b0;

  rf_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .RF_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addra(req_addra), .req_addrb(req_addrb), .req_tag(req_tag),
    .block_i(block_i), .flush_i(flush_i), .addra(addra), .addrb(addrb),
    .dataa(dataa), .datab(datab), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .rsp_dataa(rsp_dataa), .rsp_datab(rsp_datab));

  rf_read_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .RF_LATENCY(3)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_ready(rdy4),
    .req_addra(a4), .req_addrb(b4), .req_tag(t4),
    .block_i(zero_bit), .flush_i(zero_bit), .addra(addra4), .addrb(addrb4),
    .dataa(zero_data), .datab(zero_data), .rsp_valid(rv4), .rsp_tag(rt4),
    .rsp_dataa(rda4), .rsp_datab(rdb4));

  // Register-file model with one cycle of read latency.
  logic [DW-1:0] rf_a [128];
  logic [DW-1:0] rf_b [128];
  always @(posedge clk) begin
    dataa <= rf_a[addra];
    datab <= rf_b[addrb];
  end

  int total = 0;
  int bad   = 0;

  // Reference state: pointer, expected addresses, responses indexed by cycle.
  int          cyc = 0;
  int          m_ptr = 0;
  logic [AW-1:0] m_aa = 7'd0, m_ab = 7'd0;
  bit          m_known = 1'b1;
  logic [N-1:0]  s_rv [1024];
  logic [TW-1:0] s_tg [1024];
  logic [DW-1:0] s_da [1024];
  logic [DW-1:0] s_db [1024];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rnd_fields();
    for (int i = 0; i < N; i++) begin
      req_addra[i*AW +: AW] = 7'($urandom);
      req_addrb[i*AW +: AW] = 7'($urandom);
      req_tag[i*TW +: TW]   = 4'($urandom);
    end
  endtask

  task automatic clear_future();
    for (int c = cyc + 1; c < 1024; c++) begin
      s_rv[c] = 3'b000;
      s_tg[c] = 4'h0;
    end
  endtask

  // One clock cycle: drive, predict, compare at mid-cycle, then advance the model.
  task automatic run_cycle(input logic [N-1:0] v, input logic blk, input logic fl,
                           input logic rs, input bit rnd);
    logic [N-1:0] exp_rdy;
    logic [N-1:0] probe;
    int w;
    int idx;
    if (rnd) rnd_fields();
    req_valid = v;
    block_i   = blk;
    flush_i   = fl;
    reset     = rs;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx   = (m_ptr + k) % N;
      probe = N'(1) << idx;
      if (w < 0 && (v & probe) != 3'b000) w = idx;
    end
    exp_rdy = 3'b000;
    if (rs && !blk && !fl && w >= 0) exp_rdy = N'(1) << w;
    #4;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(s_rv[cyc]));
    chk("rsp_tag",   64'(rsp_tag),   64'(s_tg[cyc]));
    if (s_rv[cyc] != 3'b000) begin
      chk("rsp_dataa", 64'(rsp_dataa), 64'(s_da[cyc]));
      chk("rsp_datab", 64'(rsp_datab), 64'(s_db[cyc]));
    end
    if (m_known) begin
      chk("addra", 64'(addra), 64'(m_aa));
      chk("addrb", 64'(addrb), 64'(m_ab));
    end
    @(posedge clk);
    if (!rs) begin
      clear_future();
      m_ptr = 0; m_aa = 7'd0; m_ab = 7'd0; m_known = 1'b1;
    end else if (fl) begin
      clear_future();
      m_known = 1'b0;
    end else if (exp_rdy != 3'b000) begin
      m_ptr   = (w + 1) % N;
      m_aa    = req_addra[w*AW +: AW];
      m_ab    = req_addrb[w*AW +: AW];
      m_known = 1'b1;
      s_rv[cyc + 1 + LAT] = exp_rdy;
      s_tg[cyc + 1 + LAT] = req_tag[w*TW +: TW];
      s_da[cyc + 1 + LAT] = rf_a[m_aa];
      s_db[cyc + 1 + LAT] = rf_b[m_ab];
    end
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      rf_a[i] = $urandom;
      rf_b[i] = $urandom;
    end
    for (int c = 0; c < 1024; c++) begin
      s_rv[c] = 3'b000; s_tg[c] = 4'h0; s_da[c] = 32'h0; s_db[c] = 32'h0;
    end
    reset = 1'b0; req_valid = 3'b000; block_i = 1'b0; flush_i = 1'b0;
    req_addra = 21'h0; req_addrb = 21'h0; req_tag = 12'h0;
    v4 = 4'h0; a4 = {7'd40, 7'd30, 7'd20, 7'd10}; b4 = {7'd41, 7'd31, 7'd21, 7'd11};
    t4 = {4'd4, 4'd3, 4'd2, 4'd1};
    @(posedge clk); #1;

    // Reset holds ready low even with all requests pending.
    run_cycle(3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(3'b111, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single request: addr 5/9, tag A.
    req_addra = {7'd0, 7'd0, 7'd5};
    req_addrb = {7'd0, 7'd0, 7'd9};
    req_tag   = {4'h0, 4'h0, 4'hA};
    run_cycle(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fairness from pointer 0: six back-to-back grants.
    run_cycle(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) run_cycle(3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Block for two cycles with all pending; resume at requester 1.
    run_cycle(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b111, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b111, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Flush in the cycle after a grant; the following grant survives.
    run_cycle(3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b101, 1'b0, 1'b1, 1'b1, 1'b1);
    run_cycle(3'b100, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Block and flush together: flush wins.
    run_cycle(3'b011, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b011, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset with two reads in flight; next grant goes to requester 0.
    run_cycle(3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cycle(3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic with occasional block, flush and reset.
    for (int i = 0; i < 300; i++) begin
      run_cycle(3'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                !($urandom_range(0, 49) == 0), 1'b1);
    end
    for (int i = 0; i < 3; i++) run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Four requesters, latency 3: grants 0,1,2,3,0 and responses 4 cycles later.
    for (int k = 0; k < 10; k++) begin
      v4 = (k < 5) ? 4'hF : 4'h0;
      #4;
      chk("d4_ready", 64'(rdy4), 64'((k < 5) ? (4'b0001 << (k % 4)) : 4'b0000));
      if (k >= 4 && k <= 8) begin
        chk("d4_rsp_valid", 64'(rv4), 64'(4'b0001 << ((k - 4) % 4)));
        chk("d4_rsp_tag",   64'(rt4), 64'(((k - 4) % 4) + 1));
      end else begin
        chk("d4_rsp_valid", 64'(rv4), 64'h0);
        chk("d4_rsp_tag",   64'(rt4), 64'h0);
      end
      if (k >= 1 && k <= 5) begin
        chk("d4_addra", 64'(addra4), 64'(10 * (((k - 1) % 4) + 1)));
        chk("d4_addrb", 64'(addrb4), 64'(10 * (((k - 1) % 4) + 1) + 1));
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
